// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types for the instruction fetch unit
`include "sizes.vh"

package ifetch_pkg;

    localparam int ADDR_W = `HBIT_ADDR + 1;
    localparam int DATA_W = `HBIT_DATA + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // One outstanding memory read: killed reads keep their slot but drop live
    typedef struct packed {
        logic  live;
        addr_t pc;
    } tag_t;

    // One fetched instruction waiting for decode
    typedef struct packed {
        data_t instr;
        addr_t pc;
    } entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch_queue: synchronous FIFO with flush and same-cycle push/pop
`include "sizes.vh"

module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int     DEPTH = 2,
    parameter entry_t INIT  = '0
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    assign head = mem[rd_ptr];

    // Pointer/count bookkeeping; flush wins over any push or pop this cycle
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sizes.vh
// rtl/sizes.vh - shared address/data width macros
`ifndef SIZES_VH
`define SIZES_VH
`define HBIT_ADDR 11
`define HBIT_DATA 15
`endif

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: credit-based memory reads into a small queue
`include "sizes.vh"

module ifetch
    import ifetch_pkg::*;
#(
    parameter addr_t RESET_PC = 12'h000,
    parameter int    QDEPTH   = 2
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    output logic [`HBIT_ADDR:0]  or_mem_addr,
    input  logic [`HBIT_DATA:0]  iw_mem_rdata,
    input  logic                 iw_redirect,
    input  logic [`HBIT_ADDR:0]  iw_redirect_pc,
    output logic                 or_valid,
    input  logic                 iw_ready,
    output logic [`HBIT_DATA:0]  or_instr,
    output logic [`HBIT_ADDR:0]  or_pc
);

    localparam int     CW        = $clog2(QDEPTH) + 1;
    localparam entry_t RST_ENTRY = '{instr: '0, pc: RESET_PC};

    addr_t           r_pc;
    tag_t            tag;
    entry_t          head;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            pop;
    logic            push;
    logic            issue;

    // No transfer is offered in a reset cycle, so nothing is lost downstream
    assign or_valid    = iw_rst_n && (count != '0);
    assign pop         = or_valid && iw_ready;
    assign credit      = {1'b0, count} + {{CW{1'b0}}, tag.live} - {{CW{1'b0}}, pop};
    assign issue       = !iw_redirect && (credit < (CW + 1)'(QDEPTH));
    assign push        = tag.live && !iw_redirect;
    assign or_mem_addr = r_pc;
    assign or_instr    = head.instr;
    assign or_pc       = head.pc;

    // Fetch pointer: redirect target wins, otherwise advance on each issue
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_pc <= RESET_PC;
        end else if (iw_redirect) begin
            r_pc <= iw_redirect_pc;
        end else if (issue) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    // Tag for the read presented this cycle; its data returns next cycle
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            tag <= '0;
        end else begin
            tag <= '{live: issue, pc: r_pc};
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .INIT  (RST_ENTRY)
    ) u_queue (
        .iw_clk    (iw_clk),
        .iw_rst_n  (iw_rst_n),
        .flush     (iw_redirect),
        .push      (push),
        .push_data ('{instr: iw_mem_rdata, pc: tag.pc}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the fetch-queue depth (power of two, >=2).
REQ-003 SHALL have port iw_clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iw_rst_n  in  1  meaning the reset, synchronous, active-low.
REQ-005 SHALL have port or_mem_addr  out  `HBIT_ADDR+1  meaning the read address to memory read port 0 (write enable tied 0 at top level).
REQ-006 SHALL have port iw_mem_rdata  in  `HBIT_DATA+1  meaning the memory read-port-0 data, valid one cycle after the address.
REQ-007 SHALL have port iw_redirect  in  1  meaning the control-flow redirect request.
REQ-008 SHALL have port iw_redirect_pc  in  `HBIT_ADDR+1  meaning the redirect target.
REQ-009 SHALL have port or_valid  out  1  meaning the output instruction is valid.
REQ-010 SHALL have port iw_ready  in  1  meaning the downstream decode accepts; a transfer occurs when or_valid && iw_ready.
REQ-011 SHALL have port or_instr  out  `HBIT_DATA+1  meaning the instruction word at the queue head.
REQ-012 SHALL have port or_pc  out  `HBIT_ADDR+1  meaning the address of or_instr.

Function
REQ-013 SHALL drive or_mem_addr directly from the registered fetch pointer r_pc, with no combinational path from any input.
REQ-014 SHALL treat a cycle as an issue when count + inflight - pop < QDEPTH and iw_redirect=0; count = queue entries, inflight = live read from the previous cycle, pop = transfer this cycle.
REQ-015 SHALL increment r_pc modulo 4096 on issue (4095 -> 0) and hold r_pc otherwise.
REQ-016 SHALL record each issue as one in-flight tag (live bit, pc) and, in the next cycle, push {iw_mem_rdata, tag pc} into the queue if the tag is live.
REQ-017 SHALL present the queue head on or_instr/or_pc with or_valid = (count != 0); or_instr/or_pc SHALL hold stable while or_valid && !iw_ready.
REQ-018 SHALL support simultaneous push and pop in one cycle, including when the queue is full.
REQ-019 SHALL never overflow: the credit rule of REQ-014 guarantees a slot for every live in-flight read.
REQ-020 SHALL sustain one transfer per cycle when iw_ready is held high in steady state.
REQ-021 SHALL, on iw_redirect=1 in cycle t: load r_pc <= iw_redirect_pc, empty the queue, kill any in-flight tag issued in t-1, and not issue in cycle t.
REQ-022 SHALL count a transfer in the same cycle as a redirect as accepted by downstream, while the queue is still flushed.
REQ-023 SHALL, after a redirect in cycle t, issue iw_redirect_pc in cycle t+1 and assert or_valid with or_pc = iw_redirect_pc in cycle t+3.
REQ-024 SHALL give redirect priority over issue, push and pop bookkeeping.
REQ-025 SHALL accept back-to-back redirects, with only the last one taking effect.

Reset
REQ-026 SHALL, while iw_rst_n=0 at a clock edge, set r_pc=RESET_PC, count=0, inflight=0, or_valid=0 and or_instr=0, with or_pc=RESET_PC.
REQ-027 SHALL issue RESET_PC in the first cycle with iw_rst_n=1, giving or_valid=1 two cycles later.
REQ-028 SHALL, when reset asserts mid-operation, discard queue and in-flight contents with no output transfer in the reset cycle.

Structure
REQ-029 SHALL take address/data widths (`HBIT_ADDR, `HBIT_DATA) from the shared sizes.vh; RESET_PC and QDEPTH SHALL stay module parameters.
REQ-030 SHALL implement the queue as one sub-module fetch_queue (synchronous FIFO, flush input, push/pop same cycle, count output).

Verification
REQ-031 SHALL check: reset with RESET_PC=0 and iw_ready=1 -> or_pc sequence 0,1,2,... one per cycle from cycle 3 after release, or_instr = preloaded mem words.
REQ-032 SHALL check: iw_ready=0 for 10 cycles -> or_valid high, or_pc/or_instr stable, or_mem_addr stops at head+2, no lost or duplicated words after release.
REQ-033 SHALL check: redirect to 12'h800 while the queue is full -> in cycle t+3 or_pc=12'h800, with no stale pc ever valid after t.
REQ-034 SHALL check: r_pc=12'hFFE streaming -> or_pc sequence FFE, FFF, 000, 001.
REQ-035 SHALL check: redirect and transfer in the same cycle, then a second redirect next cycle -> only the second target appears.
REQ-036 SHALL check: iw_rst_n low mid-stream for 1 cycle -> or_valid=0 the next cycle, restart at RESET_PC.
